reset_sequencer: RTL and testbench

//  Reset source for downstream logic that uses async, active-high-reset flops (posedge clk, posedge rst).

---
 rtl/reset_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Top-level reset source for downstream logic built from asynchronous,
// active-high-reset flops. The board reset (rst_n) asserts every domain reset
// at once without needing a clock. Release is synchronous: a synchronizer
// chain must fill, all domains are held for HOLD_CYCLES edges, and then the
// domain resets are released one at a time, GAP_CYCLES edges apart, starting
// with bit 0.
//
// Once the sequence has finished (RUN), a synchronous software request
// restarts it from the hold phase. The synchronizer is not refilled in that
// case because the clock is already known to be running.
//
// Parameters
//   SYNC_STAGES  deassertion synchronizer depth (>= 2)
//   HOLD_CYCLES  edges all domains stay in reset after sync (>= 1)
//   NUM_DOMAINS  number of domain reset outputs (>= 1)
//   GAP_CYCLES   edges between successive domain releases (>= 1)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous, active-low board reset
//   sw_rst_req  in   synchronous software reset request, honoured only in RUN
//   rst_out     out  active-high reset per domain, bit 0 released first
//   rst_busy    out  high while any rst_out bit is high
//   rst_done    out  one-cycle pulse on the edge that releases the last domain
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 3,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   rst_busy,
    output logic                   rst_done
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sync_ok;

    // Deassertion synchronizer: ones shift in from the bottom once rst_n is
    // high; the top bit reports that rst_n has been seen high for
    // SYNC_STAGES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // State and output registers. Every output is a flop, set/cleared
    // asynchronously by rst_n, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    //
    // Domains release in ascending order from an all-ones pattern, so the
    // asserted bits always form a contiguous upper block; shifting left by one
    // clears exactly the lowest still-asserted domain.
    //
    // cnt counts edges already spent in the current phase, so a phase of
    // L edges ends on the edge where cnt equals L-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                if (sync_ok) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    out_d = out_q << 1;
                    idx_d = IW'(1);
                    if (NUM_DOMAINS == 1) begin
                        // The single domain is also the last one.
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    out_d = out_q << 1;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                if (sw_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    out_d   = '1;
                end
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                idx_d   = '0;
                out_d   = '1;
            end
        endcase

        // Derived from the next rst_out value so the registered busy flag can
        // never disagree with the registered domain resets.
        busy_d = |out_d;
    end

    assign rst_out  = out_q;
    assign rst_busy = busy_q;
    assign rst_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer. One instance uses the default
// parameters (S=2, H=16, N=3, G=4); a second uses S=3, H=1, N=1, G=1.
// Expected values are written out by hand from the release schedule:
//   power-on   : 111 before E18, 110 from E18, 100 from E22, 000 from E26
//   sw restart : 111 at R, 110 from R+16, 100 from R+20, 000 from R+24
//   rst_done is high only on the sample after the final release edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [2:0] rst_out;
    logic       rst_busy;
    logic       rst_done;

    logic       rst6_n = 1'b1;
    logic       sw6 = 1'b0;
    logic       out6;
    logic       busy6;
    logic       done6;

    int n_cmp = 0;
    int n_bad = 0;
    bit sw_hold = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .rst_busy   (rst_busy),
        .rst_done   (rst_done)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .NUM_DOMAINS (1),
        .GAP_CYCLES  (1)
    ) dut6 (
        .clk        (clk),
        .rst_n      (rst6_n),
        .sw_rst_req (sw6),
        .rst_out    (out6),
        .rst_busy   (busy6),
        .rst_done   (done6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected default-instance rst_out, n edges after the reference edge,
    // with the first release at edge 'off'.
    function automatic logic [2:0] exp_out(input int n, input int off);
        if (n < off)          return 3'b111;
        else if (n < off + 4) return 3'b110;
        else if (n < off + 8) return 3'b100;
        else                  return 3'b000;
    endfunction

    // Walk edges 0..last of the default instance, checking all three outputs
    // after each edge. pulse_at >= 0 raises sw_rst_req for one edge after
    // that sample; period > 0 folds the edge number for back-to-back runs.
    task automatic run_seq(input string name, input int off, input int last,
                           input int pulse_at, input int period);
        logic [2:0] eo;
        int m;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk);
            #1;
            if (!sw_hold) sw_rst_req = 1'b0;
            m  = (period > 0) ? (n % period) : n;
            eo = exp_out(m, off);
            chk($sformatf("%s_out_e%0d", name, n), 32'(rst_out), 32'(eo));
            chk($sformatf("%s_busy_e%0d", name, n), 32'(rst_busy), 32'(eo != 3'b000));
            chk($sformatf("%s_done_e%0d", name, n), 32'(rst_done), 32'(m == off + 8));
            if (n == pulse_at) sw_rst_req = 1'b1;
        end
    endtask

    task automatic run6(input string name);
        for (int n = 0; n <= 6; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_out_e%0d", name, n), 32'(out6), 32'(n < 4));
            chk($sformatf("%s_busy_e%0d", name, n), 32'(busy6), 32'(n < 4));
            chk($sformatf("%s_done_e%0d", name, n), 32'(done6), 32'(n == 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset asserted before any clock edge: outputs must respond at once.
        #1;
        rst_n  = 1'b0;
        rst6_n = 1'b0;
        #1;
        chk("por_out", 32'(rst_out), 32'h7);
        chk("por_busy", 32'(rst_busy), 32'h1);
        chk("por_done", 32'(rst_done), 32'h0);
        chk("por6_out", 32'(out6), 32'h1);
        chk("por6_busy", 32'(busy6), 32'h1);

        // Test 1: power-on release between edges.
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_seq("t1", 18, 27, -1, 0);

        // Test 2: async assertion from RUN, then aborts in HOLD and RELEASE.
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t2_run_abort_out", 32'(rst_out), 32'h7);
        chk("t2_run_abort_busy", 32'(rst_busy), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_seq("t2a", 18, 10, -1, 0);
        #4 rst_n = 1'b0;
        #1;
        chk("t2_hold_abort_out", 32'(rst_out), 32'h7);
        chk("t2_hold_abort_busy", 32'(rst_busy), 32'h1);
        chk("t2_hold_abort_done", 32'(rst_done), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        run_seq("t2b", 18, 20, -1, 0);
        #4 rst_n = 1'b0;
        #1;
        chk("t2_rel_abort_out", 32'(rst_out), 32'h7);
        chk("t2_rel_abort_busy", 32'(rst_busy), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        run_seq("t2c", 18, 27, -1, 0);

        // Test 3: single-cycle software request in RUN.
        @(negedge clk) sw_rst_req = 1'b1;
        run_seq("t3", 16, 26, -1, 0);

        // Test 4: request between bit-0 and bit-1 releases is ignored.
        @(negedge clk) sw_rst_req = 1'b1;
        run_seq("t4", 16, 34, 18, 0);

        // Test 5: request held high restarts right after each rst_done.
        sw_hold = 1'b1;
        @(negedge clk) sw_rst_req = 1'b1;
        run_seq("t5", 16, 49, -1, 25);
        sw_hold    = 1'b0;
        sw_rst_req = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_stop_out", 32'(rst_out), 32'h0);
        chk("t5_stop_busy", 32'(rst_busy), 32'h0);
        chk("t5_stop_done", 32'(rst_done), 32'h0);

        // Test 6: S=3,H=1,N=1,G=1 instance, then a sub-cycle rst_n glitch.
        @(negedge clk) rst6_n = 1'b1;
        run6("t6a");
        rst6_n = 1'b0;
        #1;
        chk("t6_glitch_out", 32'(out6), 32'h1);
        chk("t6_glitch_busy", 32'(busy6), 32'h1);
        chk("t6_glitch_done", 32'(done6), 32'h0);
        #1 rst6_n = 1'b1;
        run6("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
